// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the ID/EX boundary
// Purpose: ALU control codes, alu_op encodings, funct7/funct3 values and the
//          packed control record latched in ID/EX.
// Ports:   none (package).
package cpu_pkg;

   // 4-bit ALU control codes understood by the unchanged EX-stage ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_SLL = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SRA = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b1000;
   localparam logic [3:0] ALU_MUL = 4'b1010;

   typedef enum logic [1:0] {
      ALU_OP_MEM    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_RTYPE  = 2'b10,
      ALU_OP_ITYPE  = 2'b11
   } alu_op_e;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SR  = 3'b101;
   localparam logic [2:0] F3_AND = 3'b111;

   // Width-independent latched control; the data words and register
   // addresses are kept beside it so XLEN/RA_W stay parameters of the stage.
   typedef struct packed {
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
   } id_ex_t;

   // All-zero entry: no writes, no memory access, alu_ctrl AND
   localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - alu_op/funct7/funct3 to 4-bit ALU control decoder
// Purpose: pure combinational decode, evaluated on the ID-side fields and
//          stored at capture time.
// Ports:   alu_op_i   in  2  operation class (mem/branch/R/I)
//          funct7_i   in  7  instruction funct7
//          funct3_i   in  3  instruction funct3
//          alu_ctrl_o out 4  ALU control code
module alu_ctrl_dec
   import cpu_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   output logic [3:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (alu_op_e'(alu_op_i))
         ALU_OP_MEM:    alu_ctrl_o = ALU_ADD;
         ALU_OP_BRANCH: alu_ctrl_o = ALU_SUB;
         ALU_OP_RTYPE: begin
            case ({funct7_i, funct3_i})
               {F7_BASE, F3_ADD}: alu_ctrl_o = ALU_ADD;
               {F7_ALT,  F3_ADD}: alu_ctrl_o = ALU_SUB;
               {F7_MUL,  F3_ADD}: alu_ctrl_o = ALU_MUL;
               {F7_BASE, F3_XOR}: alu_ctrl_o = ALU_XOR;
               {F7_BASE, F3_SLL}: alu_ctrl_o = ALU_SLL;
               {F7_BASE, F3_AND}: alu_ctrl_o = ALU_AND;
               default:           alu_ctrl_o = ALU_ADD;
            endcase
         end
         ALU_OP_ITYPE: begin
            // funct7 only qualifies the shift; for addi it is immediate bits
            if (funct3_i == F3_SR && funct7_i == F7_ALT) begin
               alu_ctrl_o = ALU_SRA;
            end else begin
               alu_ctrl_o = ALU_ADD;
            end
         end
         default: alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and hazard detect
// Purpose: latches decoded operands/control, decodes ALU control at capture,
//          resolves operand forwarding and requests load-use stalls.
// Config:  FORWARDING_EN defined   -> EX/MEM and MEM/WB forwarding muxes,
//                                     stall only on load-use.
//          FORWARDING_EN undefined -> operands from latched data, stall on
//                                     any RAW against EX or MEM producers.
// Ports:   clk_i, rst_i (sync, active-high), hold_i, flush_i
//          id_*        decoded operands, addresses, funct fields, controls
//          mem_*/wb_*  writeback info of the EX/MEM and MEM/WB stages
//          stall_o     load-use stall request to PC and IF/ID
//          alu_data1_o/alu_data2_o/alu_ctrl_o  ALU inputs
//          ex_store_data_o, ex_rd_o, ex_*_o    registered data/control to EX/MEM
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            hold_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] id_rs1_data_i,
   input  logic [XLEN-1:0] id_rs2_data_i,
   input  logic [XLEN-1:0] id_imm_i,
   input  logic [RA_W-1:0] id_rs1_i,
   input  logic [RA_W-1:0] id_rs2_i,
   input  logic [RA_W-1:0] id_rd_i,
   input  logic [6:0]      id_funct7_i,
   input  logic [2:0]      id_funct3_i,
   input  logic [1:0]      id_alu_op_i,
   input  logic            id_alu_src_i,
   input  logic            id_reg_write_i,
   input  logic            id_mem_read_i,
   input  logic            id_mem_write_i,
   input  logic            id_mem_to_reg_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic            mem_reg_write_i,
   input  logic [XLEN-1:0] mem_alu_result_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic            wb_reg_write_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            stall_o,
   output logic [XLEN-1:0] alu_data1_o,
   output logic [XLEN-1:0] alu_data2_o,
   output logic [3:0]      alu_ctrl_o,
   output logic [XLEN-1:0] ex_store_data_o,
   output logic [RA_W-1:0] ex_rd_o,
   output logic            ex_reg_write_o,
   output logic            ex_mem_read_o,
   output logic            ex_mem_write_o,
   output logic            ex_mem_to_reg_o
);

   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [RA_W-1:0] rs1_q, rs1_d;
   logic [RA_W-1:0] rs2_q, rs2_d;
   logic [RA_W-1:0] rd_q, rd_d;
   id_ex_t          ctrl_q, ctrl_d;

   logic [3:0]      dec_alu_ctrl;
   logic            hazard;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;

   alu_ctrl_dec u_alu_ctrl_dec (
      .alu_op_i   (id_alu_op_i),
      .funct7_i   (id_funct7_i),
      .funct3_i   (id_funct3_i),
      .alu_ctrl_o (dec_alu_ctrl)
   );

   // x0 is never a producer, so rd==0 never raises a hazard
   logic id_uses_ex_rd;
   assign id_uses_ex_rd = (rd_q != '0) && (rd_q == id_rs1_i || rd_q == id_rs2_i);

`ifdef FORWARDING_EN
   // Only a load still in EX cannot be forwarded in time
   assign hazard = ctrl_q.mem_read && id_uses_ex_rd;

   always_comb begin
      rs1_fwd = rs1_data_q;
      if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == rs1_q) begin
         rs1_fwd = mem_alu_result_i;
      end else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rs1_q) begin
         rs1_fwd = wb_data_i;
      end
   end

   always_comb begin
      rs2_fwd = rs2_data_q;
      if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == rs2_q) begin
         rs2_fwd = mem_alu_result_i;
      end else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rs2_q) begin
         rs2_fwd = wb_data_i;
      end
   end
`else
   // Without forwarding, any producer in EX or MEM blocks the consumer;
   // the register file write-through covers the WB stage.
   logic id_uses_mem_rd;
   assign id_uses_mem_rd = (mem_rd_i != '0) && (mem_rd_i == id_rs1_i || mem_rd_i == id_rs2_i);
   assign hazard = (ctrl_q.reg_write && id_uses_ex_rd) || (mem_reg_write_i && id_uses_mem_rd);

   assign rs1_fwd = rs1_data_q;
   assign rs2_fwd = rs2_data_q;

   logic unused_fwd;
   assign unused_fwd = ^{mem_alu_result_i, wb_rd_i, wb_reg_write_i, wb_data_i, rs1_q, rs2_q};
`endif

   // A frozen or squashed pipeline must not also ask upstream to stall
   assign stall_o = hazard && !hold_i && !flush_i;

   always_comb begin
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      ctrl_d     = ctrl_q;
      if (!hold_i) begin
         if (flush_i || stall_o) begin
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            ctrl_d     = ID_EX_BUBBLE;
         end else begin
            rs1_data_d        = id_rs1_data_i;
            rs2_data_d        = id_rs2_data_i;
            imm_d             = id_imm_i;
            rs1_d             = id_rs1_i;
            rs2_d             = id_rs2_i;
            rd_d              = id_rd_i;
            ctrl_d.alu_ctrl   = dec_alu_ctrl;
            ctrl_d.alu_src    = id_alu_src_i;
            ctrl_d.reg_write  = id_reg_write_i;
            ctrl_d.mem_read   = id_mem_read_i;
            ctrl_d.mem_write  = id_mem_write_i;
            ctrl_d.mem_to_reg = id_mem_to_reg_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         ctrl_q     <= ID_EX_BUBBLE;
      end else begin
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign alu_data1_o     = rs1_fwd;
   assign alu_data2_o     = ctrl_q.alu_src ? imm_q : rs2_fwd;
   assign alu_ctrl_o      = ctrl_q.alu_ctrl;
   assign ex_store_data_o = rs2_fwd;
   assign ex_rd_o         = rd_q;
   assign ex_reg_write_o  = ctrl_q.reg_write;
   assign ex_mem_read_o   = ctrl_q.mem_read;
   assign ex_mem_write_o  = ctrl_q.mem_write;
   assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
// Purpose: decode table, hand-written hazard/flush/hold/reset sequences and
//          randomized stimulus against a behavioural model.
// Ports:   none (top-level bench). Honors FORWARDING_EN like the design.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, hold, flush;
   logic [31:0] rs1d, rs2d, imm;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [1:0]  op;
   logic        src, rw, mr, mw, m2r;
   logic [4:0]  mem_rd, wb_rd;
   logic        mem_rw, wb_rw;
   logic [31:0] mem_res, wb_data;

   logic        stall;
   logic [31:0] d1, d2, st;
   logic [3:0]  actl;
   logic [4:0]  ex_rd;
   logic        ex_rw, ex_mr, ex_mw, ex_m2r;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
      .id_rs1_data_i(rs1d), .id_rs2_data_i(rs2d), .id_imm_i(imm),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
      .id_funct7_i(f7), .id_funct3_i(f3), .id_alu_op_i(op),
      .id_alu_src_i(src), .id_reg_write_i(rw), .id_mem_read_i(mr),
      .id_mem_write_i(mw), .id_mem_to_reg_i(m2r),
      .mem_rd_i(mem_rd), .mem_reg_write_i(mem_rw), .mem_alu_result_i(mem_res),
      .wb_rd_i(wb_rd), .wb_reg_write_i(wb_rw), .wb_data_i(wb_data),
      .stall_o(stall), .alu_data1_o(d1), .alu_data2_o(d2), .alu_ctrl_o(actl),
      .ex_store_data_o(st), .ex_rd_o(ex_rd), .ex_reg_write_o(ex_rw),
      .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw), .ex_mem_to_reg_o(ex_m2r)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference ----------------
   logic [31:0] m_rs1d, m_rs2d, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [3:0]  m_ctrl;
   logic        m_src, m_rw, m_mr, m_mw, m_m2r;

   function automatic logic [3:0] ref_ctrl(input logic [1:0] o, input logic [6:0] a, input logic [2:0] b);
      if (o == 2'b00) return 4'b0010;
      if (o == 2'b01) return 4'b0110;
      if (o == 2'b10) begin
         if (a == 7'b0000000 && b == 3'b000) return 4'b0010;
         if (a == 7'b0100000 && b == 3'b000) return 4'b0110;
         if (a == 7'b0000001 && b == 3'b000) return 4'b1010;
         if (a == 7'b0000000 && b == 3'b100) return 4'b1000;
         if (a == 7'b0000000 && b == 3'b001) return 4'b0001;
         if (a == 7'b0000000 && b == 3'b111) return 4'b0000;
         return 4'b0010;
      end
      if (b == 3'b101 && a == 7'b0100000) return 4'b0101;
      return 4'b0010;
   endfunction

   function automatic logic id_reads(input logic [4:0] r);
      return (r != 5'd0) && (r == rs1 || r == rs2);
   endfunction

   function automatic logic exp_stall();
      logic h;
`ifdef FORWARDING_EN
      h = m_mr && id_reads(m_rd);
`else
      h = (m_rw && id_reads(m_rd)) || (mem_rw && id_reads(mem_rd));
`endif
      return h && !hold && !flush;
   endfunction

   function automatic logic [31:0] exp_src(input logic [4:0] r, input logic [31:0] v);
`ifdef FORWARDING_EN
      if (r != 5'd0 && mem_rw && mem_rd == r) return mem_res;
      if (r != 5'd0 && wb_rw && wb_rd == r) return wb_data;
`endif
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst || (!hold && (flush || exp_stall()))) begin
         m_rs1d <= '0; m_rs2d <= '0; m_imm <= '0;
         m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_ctrl <= '0;
         m_src <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0;
      end else if (!hold) begin
         m_rs1d <= rs1d; m_rs2d <= rs2d; m_imm <= imm;
         m_rs1 <= rs1; m_rs2 <= rs2; m_rd <= rd; m_ctrl <= ref_ctrl(op, f7, f3);
         m_src <= src; m_rw <= rw; m_mr <= mr; m_mw <= mw; m_m2r <= m2r;
      end
   end

   task automatic check_model();
      chk("rnd.stall", stall, exp_stall());
      chk("rnd.data1", d1, exp_src(m_rs1, m_rs1d));
      chk("rnd.data2", d2, m_src ? m_imm : exp_src(m_rs2, m_rs2d));
      chk("rnd.store", st, exp_src(m_rs2, m_rs2d));
      chk("rnd.ctrl", actl, m_ctrl);
      chk("rnd.rd", ex_rd, m_rd);
      chk("rnd.ctl_bits", {ex_rw, ex_mr, ex_mw, ex_m2r}, {m_rw, m_mr, m_mw, m_m2r});
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      rst = 0; hold = 0; flush = 0;
      rs1d = 0; rs2d = 0; imm = 0; rs1 = 0; rs2 = 0; rd = 0;
      f7 = 0; f3 = 0; op = 0; src = 0; rw = 0; mr = 0; mw = 0; m2r = 0;
      mem_rd = 0; mem_rw = 0; mem_res = 0; wb_rd = 0; wb_rw = 0; wb_data = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic load_x5();
      idle(); op = 2'b00; mr = 1; rw = 1; m2r = 1; rd = 5'd5; rs1 = 5'd1;
      step();
   endtask

   typedef struct {
      logic [1:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [3:0] exp;
   } dec_vec_t;

   dec_vec_t tv [14];

   initial begin
      tv[0]  = '{2'b00, 7'b0100000, 3'b101, 4'b0010};
      tv[1]  = '{2'b01, 7'b0000000, 3'b000, 4'b0110};
      tv[2]  = '{2'b10, 7'b0000000, 3'b000, 4'b0010};
      tv[3]  = '{2'b10, 7'b0100000, 3'b000, 4'b0110};
      tv[4]  = '{2'b10, 7'b0000001, 3'b000, 4'b1010};
      tv[5]  = '{2'b10, 7'b0000000, 3'b100, 4'b1000};
      tv[6]  = '{2'b10, 7'b0000000, 3'b001, 4'b0001};
      tv[7]  = '{2'b10, 7'b0000000, 3'b111, 4'b0000};
      tv[8]  = '{2'b10, 7'b0100000, 3'b101, 4'b0010};
      tv[9]  = '{2'b10, 7'b0000000, 3'b010, 4'b0010};
      tv[10] = '{2'b11, 7'b0100000, 3'b000, 4'b0010};
      tv[11] = '{2'b11, 7'b0100000, 3'b101, 4'b0101};
      tv[12] = '{2'b11, 7'b0000000, 3'b101, 4'b0010};
      tv[13] = '{2'b11, 7'b0000000, 3'b001, 4'b0010};

      // reset
      idle(); rst = 1;
      step(); step();
      rst = 0;
      at_neg();
      chk("reset.stall", stall, 0);
      chk("reset.data1", d1, 0);
      chk("reset.data2", d2, 0);
      chk("reset.ctrl", actl, 4'b0000);
      chk("reset.store", st, 0);
      chk("reset.rd", ex_rd, 0);
      chk("reset.ctl_bits", {ex_rw, ex_mr, ex_mw, ex_m2r}, 4'b0000);

      // decode table
      for (int i = 0; i < 14; i++) begin
         idle(); op = tv[i].op; f7 = tv[i].f7; f3 = tv[i].f3;
         step(); at_neg();
         chk($sformatf("dec[%0d]", i), actl, tv[i].exp);
      end

      // srai x?,x?,3
      idle(); op = 2'b11; f7 = 7'b0100000; f3 = 3'b101; imm = 32'd3; src = 1; rs1d = 32'd100;
      step(); at_neg();
      chk("srai.ctrl", actl, 4'b0101);
      chk("srai.data2", d2, 32'd3);

      // sw: store data is rs2, not the immediate
      idle(); op = 2'b00; src = 1; mw = 1; rs2 = 5'd2; rs2d = 32'h55; imm = 32'd8;
      step(); at_neg();
      chk("sw.store", st, 32'h55);
      chk("sw.data2", d2, 32'd8);
      chk("sw.mw", ex_mw, 1);
`ifdef FORWARDING_EN
      mem_rd = 5'd2; mem_rw = 1; mem_res = 32'h77;
      #1;
      chk("sw.store_fwd", st, 32'h77);
      chk("sw.data2_fwd", d2, 32'd8);
`endif

      // flush squashes a valid instruction
      idle(); rw = 1; mw = 1; rd = 5'd7; op = 2'b10; flush = 1;
      step(); at_neg();
      chk("flush.rw", ex_rw, 0);
      chk("flush.mw", ex_mw, 0);
      chk("flush.rd", ex_rd, 0);

      // hold for three cycles keeps contents
      idle(); rw = 1; rd = 5'd9; rs1d = 32'h1234; op = 2'b10; f7 = 7'b0000001;
      step();
      hold = 1; rd = 5'd3; rs1d = 32'hFFFF; f7 = 0; rw = 0;
      for (int k = 0; k < 3; k++) begin
         step(); at_neg();
         chk("hold.rd", ex_rd, 5'd9);
         chk("hold.rw", ex_rw, 1);
         chk("hold.data1", d1, 32'h1234);
         chk("hold.ctrl", actl, 4'b1010);
      end

      // flush together with load-use gives exactly one bubble
      load_x5();
      idle(); rs2 = 5'd5; rw = 1; rd = 5'd6; op = 2'b10; flush = 1;
      at_neg();
      chk("flush_lu.stall", stall, 0);
      step(); at_neg();
      chk("flush_lu.mr", ex_mr, 0);
      chk("flush_lu.rw", ex_rw, 0);
      flush = 0;
      #1;
      chk("flush_lu.stall_after", stall, 0);
      step(); at_neg();
      chk("flush_lu.rd", ex_rd, 5'd6);
      chk("flush_lu.rw2", ex_rw, 1);

      // hold during pending load-use, then release
      load_x5();
      idle(); rs2 = 5'd5; rw = 1; rd = 5'd6; hold = 1;
      at_neg();
      chk("hold_lu.stall", stall, 0);
      step(); step(); at_neg();
      chk("hold_lu.mr", ex_mr, 1);
      hold = 0;
      #1;
      chk("hold_lu.stall_rel", stall, 1);

      // reset mid-stall
      rst = 1;
      #1;
      chk("rst_lu.stall_pre", stall, 1);
      step(); at_neg();
      chk("rst_lu.stall", stall, 0);
      chk("rst_lu.mr", ex_mr, 0);
      rst = 0;

`ifdef FORWARDING_EN
      // add x3,x1,x2: EX/MEM beats MEM/WB
      idle(); rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; rw = 1; op = 2'b10; rs1d = 32'hAA; rs2d = 32'hBB;
      step();
      idle(); mem_rd = 5'd1; mem_rw = 1; mem_res = 32'h10; wb_rd = 5'd1; wb_rw = 1; wb_data = 32'h20;
      at_neg();
      chk("fwd.mem_wins", d1, 32'h10);
      mem_rw = 0;
      #1;
      chk("fwd.wb", d1, 32'h20);
      mem_rd = 0; mem_rw = 1; wb_rd = 0;
      #1;
      chk("fwd.x0", d1, 32'hAA);

      // lw x5 then consumer of x5
      load_x5();
      idle(); rs1 = 5'd4; rs2 = 5'd5; rw = 1; rd = 5'd8; op = 2'b10; rs2d = 32'h999;
      at_neg();
      chk("lu.stall", stall, 1);
      step(); at_neg();
      chk("lu.bubble_rw", ex_rw, 0);
      chk("lu.bubble_mr", ex_mr, 0);
      chk("lu.stall_release", stall, 0);
      step();
      wb_rd = 5'd5; wb_rw = 1; wb_data = 32'hCAFE;
      at_neg();
      chk("lu.wb_fwd", d2, 32'hCAFE);
      chk("lu.rd", ex_rd, 5'd8);
`else
      // RAW against EX then MEM producer stalls two cycles
      idle(); rw = 1; rd = 5'd5; op = 2'b10;
      step();
      idle(); rs1 = 5'd5; rw = 1; rd = 5'd6; rs1d = 32'h4242; op = 2'b10;
      at_neg();
      chk("raw.stall_ex", stall, 1);
      step();
      mem_rd = 5'd5; mem_rw = 1;
      at_neg();
      chk("raw.stall_mem", stall, 1);
      chk("raw.bubble", ex_rw, 0);
      step();
      mem_rd = 0; mem_rw = 0;
      at_neg();
      chk("raw.release", stall, 0);
      step(); at_neg();
      chk("raw.data1", d1, 32'h4242);
      chk("raw.rd", ex_rd, 5'd6);
`endif

      // randomized against the model
      idle();
      step();
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 31) == 0);
         hold  = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 5) == 0);
         rs1d = $urandom; rs2d = $urandom; imm = $urandom;
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: f7 = 7'b0000000;
            1: f7 = 7'b0100000;
            2: f7 = 7'b0000001;
            default: f7 = 7'($urandom);
         endcase
         f3 = 3'($urandom); op = 2'($urandom);
         src = 1'($urandom); rw = 1'($urandom); mr = 1'($urandom);
         mw = 1'($urandom); m2r = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 3)); mem_rw = 1'($urandom); mem_res = $urandom;
         wb_rd = 5'($urandom_range(0, 3)); wb_rw = 1'($urandom); wb_data = $urandom;
         at_neg();
         check_model();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
